// File: rtl/btc_rx_ctrl_pkg.sv
// ============================================================================
// Module  : btc_rx_ctrl_pkg
// Brief   : Shared board-time-code message definitions (marker, flag, lengths,
//           abort cause codes) used by both transmit and receive paths.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package btc_rx_ctrl_pkg;

  // Frame delimiters and header bytes
  localparam logic [7:0] MARKER_MASTER        = 8'hA5;
  localparam logic [7:0] FLAG_BOARD_TIME_CODE = 8'h3C;
  localparam logic [7:0] BTC_N1               = 8'h00;
  localparam logic [7:0] BTC_N2               = 8'h05;

  localparam int         BTC_PL_BYTES         = 5;
  localparam int         BTC_W                = 8 * BTC_PL_BYTES;

  // Abort cause codes reported on err_code
  localparam logic [2:0] ERR_NONE             = 3'd0;
  localparam logic [2:0] ERR_BAD_FLAG         = 3'd1;
  localparam logic [2:0] ERR_BAD_LEN          = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT          = 3'd3;
  localparam logic [2:0] ERR_LINE             = 3'd4;

endpackage

`default_nettype wire

// File: rtl/btc_rx_ctrl.sv
// ============================================================================
// Module  : btc_rx_ctrl
// Brief   : Receive-side parser for board-time-code frames; delivers a 40-bit
//           time code atomically and reports aborted frames with a cause code.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btc_rx_ctrl
  import btc_rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        d,
  input  logic              d_vld,
  input  logic              d_err,
  output logic [BTC_W-1:0]  btc,
  output logic              btc_vld,
  output logic              err,
  output logic [2:0]        err_code,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLAG    = 3'd1,
    S_N1      = 3'd2,
    S_N2      = 3'd3,
    S_PAYLOAD = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       c_cnt_last = 3'(BTC_PL_BYTES - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_cnt;
  logic [31:0]      r_shift;

  logic             w_abort;
  logic [2:0]       w_code;
  logic             w_take;

  // Abort priority inside a frame: line error, then header mismatch, then gap timeout.
  always_comb begin
    w_abort = 1'b0;
    w_code  = ERR_LINE;
    if (r_state != S_IDLE) begin
      if (d_err) begin
        w_abort = 1'b1;
        w_code  = ERR_LINE;
      end else if (d_vld) begin
        case (r_state)
          S_FLAG: begin
            if (d != FLAG_BOARD_TIME_CODE) begin
              w_abort = 1'b1;
              w_code  = ERR_BAD_FLAG;
            end
          end
          S_N1: begin
            if (d != BTC_N1) begin
              w_abort = 1'b1;
              w_code  = ERR_BAD_LEN;
            end
          end
          S_N2: begin
            if (d != BTC_N2) begin
              w_abort = 1'b1;
              w_code  = ERR_BAD_LEN;
            end
          end
          default: ;
        endcase
      end else if (r_tmr == c_tmr_last) begin
        w_abort = 1'b1;
        w_code  = ERR_TIMEOUT;
      end
    end
  end

  assign w_take = d_vld && !d_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      btc      <= '0;
      btc_vld  <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      busy     <= 1'b0;
    end else begin
      btc_vld <= 1'b0;
      err     <= 1'b0;

      if (w_abort) begin
        err      <= 1'b1;
        err_code <= w_code;
        r_state  <= S_IDLE;
        busy     <= 1'b0;
        r_tmr    <= '0;
      end else if (w_take) begin
        r_tmr <= '0;
        case (r_state)
          S_IDLE: begin
            if (d == MARKER_MASTER) begin
              r_state <= S_FLAG;
              busy    <= 1'b1;
            end
          end
          S_FLAG: r_state <= S_N1;
          S_N1:   r_state <= S_N2;
          S_N2: begin
            r_state <= S_PAYLOAD;
            r_cnt   <= '0;
          end
          S_PAYLOAD: begin
            r_shift <= {r_shift[23:0], d};
            r_cnt   <= r_cnt + 3'd1;
            // Final byte: commit the whole code in one edge so btc never tears.
            if (r_cnt == c_cnt_last) begin
              btc     <= {r_shift, d};
              btc_vld <= 1'b1;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btc_rx_ctrl.sv
// ============================================================================
// Module  : tb_btc_rx_ctrl
// Brief   : Self-checking bench for btc_rx_ctrl: vector table, directed corner
//           sequences and random traffic against a frame-queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_btc_rx_ctrl;
  import btc_rx_ctrl_pkg::*;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  d = 8'h00;
  logic        d_vld = 1'b0;
  logic        d_err = 1'b0;
  logic [39:0] btc;
  logic        btc_vld;
  logic        err;
  logic [2:0]  err_code;
  logic        busy;

  always #5 clk = ~clk;

  btc_rx_ctrl #(.TIMEOUT_CYCLES(TO), .TMR_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .d_vld    (d_vld),
    .d_err    (d_err),
    .btc      (btc),
    .btc_vld  (btc_vld),
    .err      (err),
    .err_code (err_code),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a frame is the list of bytes accepted so far.
  logic [7:0]  m_q[$];
  int          m_gap;
  logic [39:0] m_btc;
  logic        m_bv;
  logic        m_err;
  logic [2:0]  m_code;

  function automatic void model_reset();
    m_q.delete();
    m_gap  = 0;
    m_btc  = '0;
    m_bv   = 1'b0;
    m_err  = 1'b0;
    m_code = 3'd0;
  endfunction

  function automatic void model_abort(input logic [2:0] c);
    m_err  = 1'b1;
    m_code = c;
    m_q.delete();
    m_gap  = 0;
  endfunction

  function automatic void model_step(input logic v, input logic e, input logic [7:0] b);
    logic [2:0] bad;
    m_bv  = 1'b0;
    m_err = 1'b0;
    if (m_q.size() == 0) begin
      if (v && !e && b == MARKER_MASTER) begin
        m_q.push_back(b);
        m_gap = 0;
      end
    end else if (e) begin
      model_abort(3'd4);
    end else if (v) begin
      m_gap = 0;
      bad = 3'd0;
      if (m_q.size() == 1 && b != FLAG_BOARD_TIME_CODE) bad = 3'd1;
      if (m_q.size() == 2 && b != 8'h00) bad = 3'd2;
      if (m_q.size() == 3 && b != 8'h05) bad = 3'd2;
      if (bad != 3'd0) begin
        model_abort(bad);
      end else begin
        m_q.push_back(b);
        if (m_q.size() == 9) begin
          m_btc = {m_q[4], m_q[5], m_q[6], m_q[7], m_q[8]};
          m_bv  = 1'b1;
          m_q.delete();
        end
      end
    end else begin
      m_gap++;
      if (m_gap == TO) model_abort(3'd3);
    end
  endfunction

  task automatic step(input logic v, input logic e, input logic [7:0] b);
    logic mbusy;
    d_vld = v;
    d_err = e;
    d     = b;
    @(posedge clk);
    #1;
    model_step(v, e, b);
    mbusy = (m_q.size() != 0);
    check("model", {18'h0, btc, btc_vld, err, err_code, busy},
                   {18'h0, m_btc, m_bv, m_err, m_code, mbusy});
    check("excl", {63'h0, err & btc_vld}, 64'h0);
    d_vld = 1'b0;
    d_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  typedef struct {
    logic        v;
    logic        e;
    logic [7:0]  b;
    logic        x_bv;
    logic        x_err;
    logic [2:0]  x_code;
    logic        x_busy;
    logic [39:0] x_btc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic e, input logic [7:0] b,
                              input logic bv, input logic er, input logic [2:0] c,
                              input logic bz, input logic [39:0] bt);
    vec_t t;
    t.v = v; t.e = e; t.b = b; t.x_bv = bv; t.x_err = er;
    t.x_code = c; t.x_busy = bz; t.x_btc = bt;
    tbl.push_back(t);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  mk;
    logic [7:0]  fl;
    logic [39:0] mkdat;
    logic [7:0]  fr[9];
    logic [7:0]  b2b[20];
    logic [39:0] caps[2];
    int          t_err;
    int          pulses;
    int          p_at[2];
    int          len;
    int          mode;

    mk = MARKER_MASTER;
    fl = FLAG_BOARD_TIME_CODE;
    mkdat = {mk, mk, 8'h00, 8'hFF, 8'h01};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {19'h0, btc, btc_vld, err, err_code, busy}, 64'h0);
    rst = 1'b0;

    // Good frame, bad flag, bad lengths, ignored errors in IDLE, marker as payload
    add(1,0,mk,   0,0,0,1, 40'h0);
    add(1,0,fl,   0,0,0,1, 40'h0);
    add(1,0,8'h00,0,0,0,1, 40'h0);
    add(1,0,8'h05,0,0,0,1, 40'h0);
    add(1,0,8'h12,0,0,0,1, 40'h0);
    add(1,0,8'h34,0,0,0,1, 40'h0);
    add(1,0,8'h56,0,0,0,1, 40'h0);
    add(1,0,8'h78,0,0,0,1, 40'h0);
    add(1,0,8'h9A,1,0,0,0, 40'h123456789A);
    add(0,0,mk,   0,0,0,0, 40'h123456789A);
    add(1,0,mk,   0,0,0,1, 40'h123456789A);
    add(1,0,8'h55,0,1,1,0, 40'h123456789A);
    add(0,0,8'h00,0,0,1,0, 40'h123456789A);
    add(1,0,mk,   0,0,1,1, 40'h123456789A);
    add(1,0,fl,   0,0,1,1, 40'h123456789A);
    add(1,0,8'h00,0,0,1,1, 40'h123456789A);
    add(1,0,8'h06,0,1,2,0, 40'h123456789A);
    add(1,0,mk,   0,0,2,1, 40'h123456789A);
    add(1,0,fl,   0,0,2,1, 40'h123456789A);
    add(1,0,8'h01,0,1,2,0, 40'h123456789A);
    add(1,1,mk,   0,0,2,0, 40'h123456789A);
    add(0,1,8'h00,0,0,2,0, 40'h123456789A);
    add(1,0,mk,   0,0,2,1, 40'h123456789A);
    add(1,0,fl,   0,0,2,1, 40'h123456789A);
    add(1,0,8'h00,0,0,2,1, 40'h123456789A);
    add(1,0,8'h05,0,0,2,1, 40'h123456789A);
    add(1,0,mk,   0,0,2,1, 40'h123456789A);
    add(1,0,mk,   0,0,2,1, 40'h123456789A);
    add(1,0,8'h00,0,0,2,1, 40'h123456789A);
    add(1,0,8'hFF,0,0,2,1, 40'h123456789A);
    add(1,0,8'h01,1,0,2,0, mkdat);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].e, tbl[i].b);
      check($sformatf("vec%0d", i), {19'h0, btc, btc_vld, err, err_code, busy},
            {19'h0, tbl[i].x_btc, tbl[i].x_bv, tbl[i].x_err, tbl[i].x_code, tbl[i].x_busy});
    end

    // Truncated frame: abort exactly TO idle cycles after the last byte
    step(1,0,mk); step(1,0,fl); step(1,0,8'h00); step(1,0,8'h05);
    step(1,0,8'h11); step(1,0,8'h22); step(1,0,8'h33);
    t_err = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (t_err == 0 && err) t_err = i;
    end
    check("timeout_at", 64'(t_err), 64'(TO));
    check("timeout_code", {61'h0, err_code}, 64'd3);
    check("timeout_btc", {24'h0, btc}, {24'h0, mkdat});

    // Longest legal gap before every byte
    fr = '{mk, fl, 8'h00, 8'h05, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 9; i++) begin
      if (i != 0) idle(TO - 1);
      step(1'b1, 1'b0, fr[i]);
    end
    check("gap_vld", {63'h0, btc_vld}, 64'h1);
    check("gap_btc", {24'h0, btc}, 64'hA1B2C3D4E5);
    check("gap_code", {61'h0, err_code}, 64'd3);

    // Line error with the third payload byte
    step(1,0,mk); step(1,0,fl); step(1,0,8'h00); step(1,0,8'h05);
    step(1,0,8'h01); step(1,0,8'h02); step(1,1,8'h03);
    check("line_err", {60'h0, err, err_code}, {60'h0, 1'b1, 3'd4});
    check("line_busy", {63'h0, busy}, 64'h0);
    idle(2);
    check("line_btc", {24'h0, btc}, 64'hA1B2C3D4E5);

    // Asynchronous reset mid-payload
    step(1,0,mk); step(1,0,fl); step(1,0,8'h00); step(1,0,8'h05);
    step(1,0,8'h11); step(1,0,8'h22);
    #2;
    rst = 1'b1;
    #1;
    check("areset_now", {19'h0, btc, btc_vld, err, err_code, busy}, 64'h0);
    d_vld = 1'b1; d = 8'h33;
    @(posedge clk);
    #1;
    check("areset_hold", {19'h0, btc, btc_vld, err, err_code, busy}, 64'h0);
    d_vld = 1'b0;
    rst = 1'b0;
    model_reset();
    step(1,0,mk); step(1,0,fl); step(1,0,8'h00); step(1,0,8'h05);
    step(1,0,8'hCA); step(1,0,8'hFE); step(1,0,8'hBA); step(1,0,8'hBE); step(1,0,8'h01);
    check("post_reset_btc", {23'h0, btc, btc_vld}, {23'h0, 40'hCAFEBABE01, 1'b1});

    // Junk, then two frames back-to-back
    b2b = '{8'h00, 8'hFF,
            mk, fl, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01,
            mk, fl, 8'h00, 8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, b2b[i]);
      if (btc_vld) begin
        if (pulses < 2) begin
          caps[pulses] = btc;
          p_at[pulses] = i;
        end
        pulses++;
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first", {24'h0, caps[0]}, 64'hDEADBEEF01);
    check("b2b_second", {24'h0, caps[1]}, 64'h0011223344);
    check("b2b_spacing", 64'(p_at[1] - p_at[0]), 64'd9);

    // Random traffic against the model
    for (int f = 0; f < 200; f++) begin
      fr[0] = mk; fr[1] = fl; fr[2] = 8'h00; fr[3] = 8'h05;
      for (int k = 4; k < 9; k++) fr[k] = 8'($urandom);
      mode = int'($urandom_range(0, 19));
      len = 9;
      if (mode < 3) fr[$urandom_range(1, 3)] = 8'($urandom);
      if (mode == 3 || mode == 4) len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++)
            step(1'b0, ($urandom_range(0, 39) == 0), 8'($urandom));
        end
        if (mode == 5 && i == 6) idle(TO - 1 + int'($urandom_range(0, 1)));
        step(1'b1, ($urandom_range(0, 59) == 0), fr[i]);
      end
      if (len < 9) idle(TO + 2);
      if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 8'($urandom));
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
